scroll_obstaculos: RTL and testbench
====================================

// Module: scroll_obstaculos
// PURPOSE
//  Reader side of the obstacle pattern ROM. Selects a type code (tipo_obs) and reads the returned 7-row pattern (obstaculo).
//  Scrolls patterns right-to-left through a column buffer that drives the display.
//  Detects hero/obstacle collision and bonus pickup at the hero column, and keeps a passed-obstacle score.
//  Sits between the game FSM (run, tick, pos_heroe) and the display/score logic.
// PARAMETERS
//  ANCHO        8   visible columns in buffer (>=2)
//  HUECO        3   empty columns inserted after every pattern (>=0)
//  BONO_PERIOD  8   every BONO_PERIOD-th emitted pattern is the bonus type 16 (>=2)
// PORTS
//  clk        in   1        system clock
//  rst_n      in   1        asynchronous active-low reset
//  run        in   1        1 = game running; 0 = return to IDLE
//  tick       in   1        one-cycle scroll-step pulse
//  pos_heroe  in   3        hero row 0..6 (values 7 = no hero, never collides)
//  tipo_obs   out  5        registered type code presented to pattern ROM
//  obstaculo  in   7        ROM pattern for tipo_obs (combinational, same cycle)
//  columnas   out  7*ANCHO  buffer; column i = columnas[7*i +: 7], i=0 is hero column
//  choque     out  1        level, 1 while in CHOQUE state
//  bono       out  1        one-cycle pulse on bonus pickup
//  puntos     out  8        obstacles passed, saturating at 255
// BEHAVIOUR
//  Reset: state IDLE; columnas=0, marker=0, tipo_obs=0, gap_cnt=0, emit_cnt=0, choque=0, bono=0, puntos=0.
//  States: IDLE -(run=1)-> RUN; RUN -(collision)-> CHOQUE; RUN/CHOQUE -(run=0)-> IDLE.
//  IDLE: buffer, marker, counters, tipo_obs and puntos are cleared synchronously every cycle; tick ignored.
//  RUN, tick=1: shift col i <= col i+1 and marker i <= marker i+1; col ANCHO-1 gets:
//    gap_cnt>0: 7'b0, marker 0, gap_cnt--.
//    gap_cnt=0: obstaculo, marker=(tipo_obs==16), gap_cnt<=HUECO, emit_cnt++, and tipo_obs advances to next type.
//  Next type: if (emit_cnt+1) % BONO_PERIOD == BONO_PERIOD-1 -> 16, else next base type 0..15.
//  Visible latency: new column appears on the edge that samples tick.
//  Hit test (RUN, every cycle, on pre-shift column 0): hit = col0[pos_heroe] and pos_heroe<7.
//    hit and marker0=0 -> CHOQUE next cycle and choque=1; buffer, tipo_obs and puntos freeze; tick ignored.
//    hit and marker0=1 -> bono=1 for one cycle; col0 and marker0 clear (no shift) or shift normally (tick).
//      One pulse per bonus column only.
//  Score: in RUN on tick, if pre-shift col0!=0 and marker0=0 and no hit, puntos++ (saturate at 255).
//  Simultaneous tick and hit: collision wins; no shift, no score.
//  Simultaneous run=0 and hit: IDLE wins.
//  Reset mid-operation: asynchronous return to reset values.
// CONFIGURATION
//  LFSR_RANDOM_EN defined:
//    base type = low 4 bits of an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5).
//    The LFSR steps once per emitted pattern and reseeds in IDLE.
//  LFSR_RANDOM_EN undefined: base type is a 4-bit counter 0,1,...,15,0 (wraps), cleared in IDLE.
// STRUCTURE
//  Shared package heroe_pkg:
//    FILAS=7, TIPO_W=5, TIPO_BONO=5'd16, LFSR_SEED=8'hA5
//    state typedef {IDLE,RUN,CHOQUE}
//  Sub-module sel_tipo_obs: type sequencer (counter or LFSR, bonus insertion); advance input, tipo output.
// TESTING
//  1 Reset, then run=1 with no tick for 10 cycles -> columnas=0, tipo_obs=0, puntos=0, choque=0.
//  2 Macro off, HUECO=3, 20 ticks, pos_heroe=7 -> patterns for types 0,1,2,3,4 enter col ANCHO-1 every 4th tick.
//    Bonus type 16 is emitted as the 8th pattern.
//  3 Pattern 7'b1100011 reaches col0 with pos_heroe=0 -> choque=1 next cycle.
//    Further ticks leave columnas unchanged; run=0 -> IDLE, all cleared.
//  4 Bonus column 7'b1111111 reaches col0 with pos_heroe=3 -> bono single pulse, no choque, col0 cleared, puntos unchanged.
//  5 pos_heroe=7 with 300 obstacles passing -> puntos saturates at 255, never wraps.
//  6 Macro on -> first 4 base types match LFSR from 8'hA5; reset asserted mid-scroll -> immediate return to reset values.

Source files
------------

// File: rtl/heroe_pkg.sv
// Shared types and constants for the obstacle scroller: row count, type code
// width, bonus type, LFSR seed/step and the game state encoding.
package heroe_pkg;

    localparam int unsigned FILAS  = 7;
    localparam int unsigned TIPO_W = 5;
    localparam logic [TIPO_W-1:0] TIPO_BONO = 5'd16;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CHOQUE
    } estado_t;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/sel_tipo_obs.sv
// Obstacle type sequencer: base types from a 4-bit counter, or from an 8-bit
// LFSR when LFSR_RANDOM_EN is defined, with the bonus type every BONO_PERIOD-th pattern.
module sel_tipo_obs
    import heroe_pkg::*;
#(
    parameter int unsigned BONO_PERIOD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    output logic [TIPO_W-1:0] tipo
);

    localparam int unsigned CNT_W = $clog2(BONO_PERIOD);

    // emit_cnt is kept modulo BONO_PERIOD, which is all the bonus test needs
    logic [CNT_W-1:0]  emit_cnt_q;
    logic [CNT_W-1:0]  emit_cnt_d;
    logic [TIPO_W-1:0] tipo_q;
    logic [TIPO_W-1:0] tipo_d;
    logic [3:0]        base_next;
    logic              toca_bono;

`ifdef LFSR_RANDOM_EN
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic [7:0] lfsr_sig;

    assign lfsr_sig  = lfsr_step(lfsr_q);
    assign base_next = lfsr_sig[3:0];
`else
    logic [3:0] base_q;
    logic [3:0] base_d;

    assign base_next = base_q + 4'd1;
`endif

    assign toca_bono = (emit_cnt_q == CNT_W'(BONO_PERIOD - 2));

    always_comb begin
        emit_cnt_d = emit_cnt_q;
        tipo_d     = tipo_q;
`ifdef LFSR_RANDOM_EN
        lfsr_d     = lfsr_q;
`else
        base_d     = base_q;
`endif
        if (clear) begin
            emit_cnt_d = '0;
            tipo_d     = '0;
`ifdef LFSR_RANDOM_EN
            lfsr_d     = LFSR_SEED;
`else
            base_d     = '0;
`endif
        end else if (advance) begin
            emit_cnt_d = (emit_cnt_q == CNT_W'(BONO_PERIOD - 1)) ? '0
                                                                 : emit_cnt_q + CNT_W'(1);
            tipo_d     = toca_bono ? TIPO_BONO : TIPO_W'(base_next);
`ifdef LFSR_RANDOM_EN
            lfsr_d     = lfsr_sig;
`else
            // the base counter only moves when a base type is actually used
            if (!toca_bono) begin
                base_d = base_next;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            emit_cnt_q <= '0;
            tipo_q     <= '0;
`ifdef LFSR_RANDOM_EN
            lfsr_q     <= LFSR_SEED;
`else
            base_q     <= '0;
`endif
        end else begin
            emit_cnt_q <= emit_cnt_d;
            tipo_q     <= tipo_d;
`ifdef LFSR_RANDOM_EN
            lfsr_q     <= lfsr_d;
`else
            base_q     <= base_d;
`endif
        end
    end

    assign tipo = tipo_q;

endmodule

// File: rtl/scroll_obstaculos.sv
// Obstacle scroller: feeds ROM patterns into a right-to-left column buffer, detects
// hero collision / bonus pickup at column 0 and counts passed obstacles. Macro: LFSR_RANDOM_EN.
module scroll_obstaculos
    import heroe_pkg::*;
#(
    parameter int unsigned ANCHO       = 8,
    parameter int unsigned HUECO       = 3,
    parameter int unsigned BONO_PERIOD = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    input  logic                     tick,
    input  logic [2:0]               pos_heroe,
    output logic [TIPO_W-1:0]        tipo_obs,
    input  logic [FILAS-1:0]         obstaculo,
    output logic [FILAS*ANCHO-1:0]   columnas,
    output logic                     choque,
    output logic                     bono,
    output logic [7:0]               puntos
);

    localparam int unsigned COLS_W = FILAS * ANCHO;
    localparam int unsigned GAP_W  = (HUECO > 0) ? $clog2(HUECO + 1) : 1;

    estado_t            estado_q;
    estado_t            estado_d;
    logic [COLS_W-1:0]  cols_q;
    logic [COLS_W-1:0]  cols_d;
    logic [ANCHO-1:0]   marca_q;
    logic [ANCHO-1:0]   marca_d;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_d;
    logic [7:0]         puntos_q;
    logic [7:0]         puntos_d;
    logic               choque_q;
    logic               choque_d;
    logic               bono_q;
    logic               bono_d;
    logic               avanza;
    logic               limpia;
    logic [FILAS-1:0]   entrada;
    logic               marca_in;
    logic [7:0]         col0_ext;
    logic               hit;

    sel_tipo_obs #(
        .BONO_PERIOD (BONO_PERIOD)
    ) u_sel_tipo_obs (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (limpia),
        .advance (avanza),
        .tipo    (tipo_obs)
    );

    // Row 7 is padded with zero so pos_heroe=7 can never hit
    assign col0_ext = {1'b0, cols_q[FILAS-1:0]};
    assign hit      = col0_ext[pos_heroe];
    assign entrada  = (gap_q == '0) ? obstaculo : '0;
    assign marca_in = (gap_q == '0) && (tipo_obs == TIPO_BONO);

    always_comb begin
        estado_d = estado_q;
        cols_d   = cols_q;
        marca_d  = marca_q;
        gap_d    = gap_q;
        puntos_d = puntos_q;
        choque_d = 1'b0;
        bono_d   = 1'b0;
        avanza   = 1'b0;
        limpia   = 1'b0;
        unique case (estado_q)
            IDLE: begin
                limpia   = 1'b1;
                cols_d   = '0;
                marca_d  = '0;
                gap_d    = '0;
                puntos_d = '0;
                if (run) begin
                    estado_d = RUN;
                end
            end
            RUN: begin
                if (!run) begin
                    estado_d = IDLE;
                end else if (hit && !marca_q[0]) begin
                    estado_d = CHOQUE;
                    choque_d = 1'b1;
                end else begin
                    bono_d = hit;
                    if (tick) begin
                        cols_d  = {entrada, cols_q[COLS_W-1:FILAS]};
                        marca_d = {marca_in, marca_q[ANCHO-1:1]};
                        if (gap_q != '0) begin
                            gap_d = gap_q - GAP_W'(1);
                        end else begin
                            gap_d  = GAP_W'(HUECO);
                            avanza = 1'b1;
                        end
                        if ((cols_q[FILAS-1:0] != '0) && !marca_q[0] && !hit
                            && (puntos_q != 8'hFF)) begin
                            puntos_d = puntos_q + 8'd1;
                        end
                    end else if (hit) begin
                        // bonus collected in place: drop it so it pulses only once
                        cols_d[FILAS-1:0] = '0;
                        marca_d[0]        = 1'b0;
                    end
                end
            end
            CHOQUE: begin
                if (!run) begin
                    estado_d = IDLE;
                end else begin
                    choque_d = 1'b1;
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= IDLE;
            cols_q   <= '0;
            marca_q  <= '0;
            gap_q    <= '0;
            puntos_q <= '0;
            choque_q <= 1'b0;
            bono_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cols_q   <= cols_d;
            marca_q  <= marca_d;
            gap_q    <= gap_d;
            puntos_q <= puntos_d;
            choque_q <= choque_d;
            bono_q   <= bono_d;
        end
    end

    assign columnas = cols_q;
    assign choque   = choque_q;
    assign bono     = bono_q;
    assign puntos   = puntos_q;

endmodule

// File: tb/tb_scroll_obstaculos.sv
// Directed bench for scroll_obstaculos with a small pattern ROM model driven from tipo_obs.
module tb_scroll_obstaculos;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        tick;
    logic [2:0]  pos_heroe;
    logic [4:0]  tipo_obs;
    logic [6:0]  obstaculo;
    logic [55:0] columnas;
    logic        choque;
    logic        bono;
    logic [7:0]  puntos;

    int total;
    int bad;

    logic [6:0]  rom [0:16];
    int          exp_tipo [0:5];
    int          tipo_tras_bono;
    logic [55:0] snap_cols;
    logic [4:0]  snap_tipo;

    scroll_obstaculos #(
        .ANCHO       (8),
        .HUECO       (3),
        .BONO_PERIOD (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .tick      (tick),
        .pos_heroe (pos_heroe),
        .tipo_obs  (tipo_obs),
        .obstaculo (obstaculo),
        .columnas  (columnas),
        .choque    (choque),
        .bono      (bono),
        .puntos    (puntos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb obstaculo = (tipo_obs <= 5'd16) ? rom[tipo_obs] : 7'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 16; i++) rom[i] = 7'(i + 1);
        rom[16] = 7'b1111111;
`ifdef LFSR_RANDOM_EN
        exp_tipo = '{0, 10, 5, 10, 4, 9};
        tipo_tras_bono = 14;
`else
        exp_tipo = '{0, 1, 2, 3, 4, 5};
        tipo_tras_bono = 7;
`endif
        rst_n = 1'b0;
        run = 1'b0;
        tick = 1'b0;
        pos_heroe = 3'd7;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cols", 64'(columnas), 64'd0);
        chk("rst_tipo", 64'(tipo_obs), 64'd0);
        chk("rst_choque", 64'(choque), 64'd0);
        chk("rst_puntos", 64'(puntos), 64'd0);
        rst_n = 1'b1;

        // idle-to-run with no ticks leaves everything empty
        run = 1'b1;
        repeat (10) cyc(1'b0);
        chk("t1_cols", 64'(columnas), 64'd0);
        chk("t1_tipo", 64'(tipo_obs), 64'd0);
        chk("t1_puntos", 64'(puntos), 64'd0);
        chk("t1_choque", 64'(choque), 64'd0);
        chk("t1_bono", 64'(bono), 64'd0);

        // a pattern enters the last column every 4th tick
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b1);
            if ((k - 1) % 4 == 0) begin
                chk("t2_col7_pat", 64'(columnas[55:49]), 64'(exp_tipo[(k - 1) / 4] + 1));
                chk("t2_tipo", 64'(tipo_obs), 64'(exp_tipo[(k - 1) / 4 + 1]));
            end else begin
                chk("t2_col7_gap", 64'(columnas[55:49]), 64'd0);
            end
        end
        chk("t2_puntos20", 64'(puntos), 64'd3);
        repeat (9) cyc(1'b1);
        chk("t2_bono_col7", 64'(columnas[55:49]), 64'h7F);
        chk("t2_tipo_after_bono", 64'(tipo_obs), 64'(tipo_tras_bono));
        chk("t2_puntos29", 64'(puntos), 64'd6);
        repeat (7) cyc(1'b1);
        chk("t4_bono_col0", 64'(columnas[6:0]), 64'h7F);
        chk("t4_puntos_before", 64'(puntos), 64'd7);

        // bonus pickup in place
        pos_heroe = 3'd3;
        cyc(1'b0);
        chk("t4_bono_pulse", 64'(bono), 64'd1);
        chk("t4_no_choque", 64'(choque), 64'd0);
        chk("t4_col0_clr", 64'(columnas[6:0]), 64'd0);
        chk("t4_puntos", 64'(puntos), 64'd7);
        cyc(1'b0);
        chk("t4_bono_single", 64'(bono), 64'd0);
        chk("t4_no_choque2", 64'(choque), 64'd0);
        pos_heroe = 3'd7;

        run = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        chk("idle_cols", 64'(columnas), 64'd0);
        chk("idle_puntos", 64'(puntos), 64'd0);
        chk("idle_tipo", 64'(tipo_obs), 64'd0);

        // collision
        rom[0] = 7'b1100011;
        pos_heroe = 3'd0;
        run = 1'b1;
        cyc(1'b0);
        repeat (8) cyc(1'b1);
        chk("t3_col0", 64'(columnas[6:0]), 64'h63);
        chk("t3_pre_choque", 64'(choque), 64'd0);
        snap_cols = columnas;
        snap_tipo = tipo_obs;
        cyc(1'b1);
        chk("t3_choque", 64'(choque), 64'd1);
        chk("t3_freeze_hit", 64'(columnas), 64'(snap_cols));
        chk("t3_puntos", 64'(puntos), 64'd0);
        repeat (3) cyc(1'b1);
        chk("t3_freeze_cols", 64'(columnas), 64'(snap_cols));
        chk("t3_freeze_tipo", 64'(tipo_obs), 64'(snap_tipo));
        chk("t3_choque_hold", 64'(choque), 64'd1);
        run = 1'b0;
        cyc(1'b0);
        chk("t3_choque_off", 64'(choque), 64'd0);
        cyc(1'b0);
        chk("t3_idle_cols", 64'(columnas), 64'd0);
        chk("t3_idle_tipo", 64'(tipo_obs), 64'd0);

        // score saturation
        pos_heroe = 3'd7;
        run = 1'b1;
        cyc(1'b0);
        for (int t = 1; t <= 1300; t++) begin
            cyc(1'b1);
            if (t == 101)  chk("t5_puntos101", 64'(puntos), 64'd21);
            if (t == 1168) chk("t5_puntos1168", 64'(puntos), 64'd254);
            if (t == 1169) chk("t5_puntos1169", 64'(puntos), 64'd255);
        end
        chk("t5_puntos_sat", 64'(puntos), 64'd255);
        chk("t5_no_choque", 64'(choque), 64'd0);

        // asynchronous reset in the middle of a cycle
        chk("t6_pre_rst", 64'(columnas != 56'd0), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_cols", 64'(columnas), 64'd0);
        chk("t6_rst_puntos", 64'(puntos), 64'd0);
        chk("t6_rst_tipo", 64'(tipo_obs), 64'd0);
        chk("t6_rst_choque", 64'(choque), 64'd0);
        chk("t6_rst_bono", 64'(bono), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
